// File: rtl/alpha_pkg.sv
// Shared types and defaults for the alpha blend fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alpha_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int PIX_W_DEF  = 8;
    localparam int ALPHA_W    = 4;

    // Job sequencing states, one pixel at a time.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_SRC = 3'd1,
        RD_DST = 3'd2,
        BLEND  = 3'd3,
        WR_DST = 3'd4,
        FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/alpha_addr_gen.sv
// Pixel index counter with source/destination address adders and last-pixel flag.
// Latency: addresses are combinational from the registered bases and index.
// Backpressure: the index only advances when inc_i is asserted by the controller.
module alpha_addr_gen
    import alpha_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [ADDR_W-1:0] count_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [ADDR_W-1:0] src_next_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] src_base_q;
    logic [ADDR_W-1:0] dst_base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_nxt;

    // Latch the job geometry on load, step the index on each completed write.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            src_base_q <= '0;
            dst_base_q <= '0;
            count_q    <= '0;
            idx_q      <= '0;
        end else if (load_i) begin
            src_base_q <= src_base_i;
            dst_base_q <= dst_base_i;
            count_q    <= count_i;
            idx_q      <= '0;
        end else if (inc_i) begin
            idx_q      <= idx_nxt;
        end
    end

    // Index never exceeds count-1 while a job runs, so idx+1 cannot wrap.
    assign idx_nxt    = idx_q + ADDR_W'(1);

    // Adders truncate to ADDR_W bits, so buffers wrap silently at the top of memory.
    assign dst_addr_o = dst_base_q + idx_q;
    assign src_next_o = src_base_q + idx_nxt;
    assign last_o     = (idx_nxt == count_q);

endmodule

// File: rtl/alpha_fetch_ctrl.sv
// Fetches src/dst pixel pairs, hands them to an external blender and writes the result back.
// Latency: busy one cycle after start; per pixel 2 reads + blend + 1 write, each gated by its handshake.
// Backpressure: every memory request holds address/data until mem_ready; blend waits for alpha_done.
module alpha_fetch_ctrl
    import alpha_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PIX_W  = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  src_base,
    input  logic [ADDR_W-1:0]  dst_base,
    input  logic [ADDR_W-1:0]  pixel_count,
    input  logic [ALPHA_W-1:0] alpha_in,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic [PIX_W-1:0]   mem_wdata,
    input  logic [PIX_W-1:0]   mem_rdata,
    input  logic               mem_ready,
    output logic               alpha_en,
    output logic               read_done,
    output logic [PIX_W-1:0]   color1,
    output logic [PIX_W-1:0]   color2,
    output logic [ALPHA_W-1:0] alpha_value,
    input  logic [PIX_W-1:0]   alpha_result,
    input  logic               alpha_done,
    output logic               busy,
    output logic               done
);

    state_t             state_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               mem_ren_q;
    logic               mem_wen_q;
    logic [PIX_W-1:0]   mem_wdata_q;
    logic               alpha_en_q;
    logic               read_done_q;
    logic [PIX_W-1:0]   color1_q;
    logic [PIX_W-1:0]   color2_q;
    logic [ALPHA_W-1:0] alpha_value_q;
    logic               busy_q;
    logic               done_q;

    logic               abort_act;
    logic               job_load;
    logic               idx_inc;
    logic [ADDR_W-1:0]  dst_addr;
    logic [ADDR_W-1:0]  src_next;
    logic               last_pix;

    // Abort only matters once a job is running; it outranks every handshake.
    assign abort_act = abort && (state_q != IDLE);
    assign job_load  = (state_q == IDLE) && start && (pixel_count != '0);
    assign idx_inc   = (state_q == WR_DST) && mem_ready && !abort_act;

    alpha_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i      (clk),
        .n_rst_i    (n_rst),
        .load_i     (job_load),
        .src_base_i (src_base),
        .dst_base_i (dst_base),
        .count_i    (pixel_count),
        .inc_i      (idx_inc),
        .dst_addr_o (dst_addr),
        .src_next_o (src_next),
        .last_o     (last_pix)
    );

    // Job sequencer with all blender/memory-facing outputs registered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_ren_q     <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_wdata_q   <= '0;
            alpha_en_q    <= 1'b0;
            read_done_q   <= 1'b0;
            color1_q      <= '0;
            color2_q      <= '0;
            alpha_value_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            read_done_q <= 1'b0;
            if (abort_act) begin
                state_q    <= IDLE;
                mem_ren_q  <= 1'b0;
                mem_wen_q  <= 1'b0;
                alpha_en_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            alpha_value_q <= alpha_in;
                            if (pixel_count == '0) begin
                                // Empty job: skip memory entirely, just report completion.
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= RD_SRC;
                                busy_q     <= 1'b1;
                                mem_ren_q  <= 1'b1;
                                mem_addr_q <= src_base;
                            end
                        end
                    end
                    RD_SRC: begin
                        if (mem_ready) begin
                            color1_q   <= mem_rdata;
                            mem_addr_q <= dst_addr;
                            state_q    <= RD_DST;
                        end
                    end
                    RD_DST: begin
                        if (mem_ready) begin
                            color2_q    <= mem_rdata;
                            mem_ren_q   <= 1'b0;
                            alpha_en_q  <= 1'b1;
                            read_done_q <= 1'b1;
                            state_q     <= BLEND;
                        end
                    end
                    BLEND: begin
                        // mem_addr still holds dst[i] from the read, reused for the write.
                        if (alpha_done) begin
                            mem_wdata_q <= alpha_result;
                            alpha_en_q  <= 1'b0;
                            mem_wen_q   <= 1'b1;
                            state_q     <= WR_DST;
                        end
                    end
                    WR_DST: begin
                        if (mem_ready) begin
                            mem_wen_q <= 1'b0;
                            if (last_pix) begin
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q    <= RD_SRC;
                                mem_ren_q  <= 1'b1;
                                mem_addr_q <= src_next;
                            end
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_ren     = mem_ren_q;
    assign mem_wen     = mem_wen_q;
    assign mem_wdata   = mem_wdata_q;
    assign alpha_en    = alpha_en_q;
    assign read_done   = read_done_q;
    assign color1      = color1_q;
    assign color2      = color2_q;
    assign alpha_value = alpha_value_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Single-port memory: never read and write in the same cycle.
    a_no_rw_overlap: assert property (@(posedge clk) disable iff (!n_rst)
        !(mem_ren && mem_wen));

    // A pending read keeps its address until it is accepted (or aborted).
    a_rd_hold: assert property (@(posedge clk) disable iff (!n_rst)
        (mem_ren && !mem_ready && !abort) |=> (mem_ren && $stable(mem_addr)));

    // A pending write keeps address and data until it is accepted (or aborted).
    a_wr_hold: assert property (@(posedge clk) disable iff (!n_rst)
        (mem_wen && !mem_ready && !abort) |=> (mem_wen && $stable(mem_addr) && $stable(mem_wdata)));

endmodule

// File: tb/tb_alpha_fetch_ctrl.sv
module tb_alpha_fetch_ctrl;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic        abort;
    logic [15:0] src_base;
    logic [15:0] dst_base;
    logic [15:0] pixel_count;
    logic [3:0]  alpha_in;
    logic [15:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        alpha_en;
    logic        read_done;
    logic [7:0]  color1;
    logic [7:0]  color2;
    logic [3:0]  alpha_value;
    logic [7:0]  alpha_result;
    logic        alpha_done;
    logic        busy;
    logic        done;

    alpha_fetch_ctrl #(.ADDR_W(16), .PIX_W(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .abort        (abort),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .pixel_count  (pixel_count),
        .alpha_in     (alpha_in),
        .mem_addr     (mem_addr),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .alpha_en     (alpha_en),
        .read_done    (read_done),
        .color1       (color1),
        .color2       (color2),
        .alpha_value  (alpha_value),
        .alpha_result (alpha_result),
        .alpha_done   (alpha_done),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  dat;
    } acc_t;

    acc_t       log_q[$];
    logic [7:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    int mem_delay   = 0;
    int blend_delay = 2;
    bit mem_stall   = 0;
    int wait_cnt    = 0;
    int bcnt        = 0;
    int done_cnt    = 0;
    int act_cnt     = 0;
    int both_cnt    = 0;
    int stab_bad    = 0;
    int rd_bad      = 0;
    int abort_hit   = 0;
    bit pend        = 0;
    logic [15:0] pend_addr;
    logic        pend_ren;
    logic [7:0]  pend_wdata;

    logic [16:0] t1_exp [9] = '{17'h00010, 17'h00100, 17'h10100,
                                17'h00011, 17'h00101, 17'h10101,
                                17'h00012, 17'h00102, 17'h10102};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] bl(input logic [7:0] c1, input logic [7:0] c2, input logic [3:0] a);
        int v;
        v = (int'(c1) * int'(a) + int'(c2) * (16 - int'(a))) >> 4;
        return v[7:0];
    endfunction

    // memory + blender response, driven away from the active edge
    initial forever begin
        @(negedge clk);
        if (n_rst && (mem_ren || mem_wen) && !mem_stall) begin
            if (wait_cnt >= mem_delay) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            if (!(mem_ren || mem_wen)) wait_cnt = 0;
        end
        if (n_rst && alpha_en) begin
            bcnt++;
            if ((bcnt == 1) !== (read_done === 1'b1)) rd_bad++;
            if (bcnt == blend_delay) begin
                alpha_done   = 1'b1;
                alpha_result = bl(color1, color2, alpha_value);
            end else begin
                alpha_done = 1'b0;
            end
        end else begin
            bcnt       = 0;
            alpha_done = 1'b0;
            if (read_done === 1'b1) rd_bad++;
        end
        if (done === 1'b1) done_cnt++;
    end

    // access logger and request-stability monitor, sampling pre-edge values
    initial forever begin
        @(posedge clk);
        if (!n_rst) begin
            pend     = 0;
            wait_cnt = 0;
        end else begin
            if (mem_ren && mem_wen) both_cnt++;
            if (mem_ren || mem_wen) act_cnt++;
            if (abort && alpha_done && alpha_en) abort_hit++;
            if ((mem_ren || mem_wen) && pend &&
                (mem_addr !== pend_addr || mem_ren !== pend_ren || (mem_wen && mem_wdata !== pend_wdata)))
                stab_bad++;
            if ((mem_ren || mem_wen) && mem_ready && !abort) begin
                log_q.push_back('{we: mem_wen, addr: mem_addr, dat: (mem_wen ? mem_wdata : mem[mem_addr])});
                if (mem_wen) mem[mem_addr] = mem_wdata;
                pend     = 0;
                wait_cnt = 0;
            end else if (mem_ren || mem_wen) begin
                pend       = 1;
                pend_addr  = mem_addr;
                pend_ren   = mem_ren;
                pend_wdata = mem_wdata;
            end else begin
                pend = 0;
            end
        end
    end

    task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c, input logic [3:0] a);
        src_base    = s;
        dst_base    = d;
        pixel_count = c;
        alpha_in    = a;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1;
        end
        chk(tag, seen, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int count_writes();
        int n;
        n = 0;
        foreach (log_q[i]) if (log_q[i].we) n++;
        return n;
    endfunction

    initial begin
        int seen;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        src_base = '0; dst_base = '0; pixel_count = '0; alpha_in = '0;
        mem_ready = 1'b0; mem_rdata = '0; alpha_result = '0; alpha_done = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h20; mem[16'h0011] = 8'h40; mem[16'h0012] = 8'h80;
        mem[16'h0100] = 8'h60; mem[16'h0101] = 8'h00; mem[16'h0102] = 8'hFF;
        mem[16'h0020] = 8'h10; mem[16'h0021] = 8'hF0;
        mem[16'h0200] = 8'h30; mem[16'h0201] = 8'h0F;
        mem[16'h0030] = 8'h11; mem[16'h0031] = 8'h22;
        mem[16'hFFFF] = 8'h33; mem[16'h0000] = 8'h44;

        // reset state
        #3;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ren_wen", {mem_ren, mem_wen}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_alpha_en_rd", {alpha_en, read_done}, 0);
        chk("rst_colors", {color1, color2, alpha_value, mem_wdata}, 0);
        @(posedge clk); #1 n_rst = 1'b1;
        idle_cycles(2);

        // basic 3-pixel job, zero-wait memory
        log_q.delete(); done_cnt = 0;
        run_job(16'h0010, 16'h0100, 16'd3, 4'd8);
        chk("t1_busy", busy, 1);
        chk("t1_first_rd", {mem_ren, mem_wen, mem_addr}, {2'b10, 16'h0010});
        wait_done("t1_done", 200);
        chk("t1_busy_end", {busy, alpha_en}, 0);
        idle_cycles(3);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_nacc", log_q.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < log_q.size()) chk($sformatf("t1_acc%0d", i), {log_q[i].we, log_q[i].addr}, t1_exp[i]);
        if (log_q.size() == 9) begin
            chk("t1_wd0", log_q[2].dat, 8'h40);
            chk("t1_wd1", log_q[5].dat, 8'h20);
            chk("t1_wd2", log_q[8].dat, 8'hBF);
        end

        // slow memory, 4 wait cycles per access
        log_q.delete(); done_cnt = 0; stab_bad = 0; mem_delay = 4;
        run_job(16'h0020, 16'h0200, 16'd2, 4'd4);
        wait_done("t2_done", 400);
        idle_cycles(2);
        chk("t2_stable", stab_bad, 0);
        chk("t2_nacc", log_q.size(), 6);
        if (log_q.size() == 6) begin
            chk("t2_w0", {log_q[2].we, log_q[2].addr, log_q[2].dat}, {1'b1, 16'h0200, 8'h28});
            chk("t2_w1", {log_q[5].we, log_q[5].addr, log_q[5].dat}, {1'b1, 16'h0201, 8'h47});
        end
        chk("t2_done_cnt", done_cnt, 1);
        mem_delay = 0;

        // empty job
        done_cnt = 0; act_cnt = 0;
        run_job(16'h0040, 16'h0400, 16'd0, 4'd5);
        chk("t3_done_next", {done, busy}, 2'b10);
        idle_cycles(3);
        chk("t3_no_access", act_cnt, 0);
        chk("t3_done_cnt", done_cnt, 1);

        // destination wraps past 0xFFFF
        log_q.delete(); done_cnt = 0;
        run_job(16'h0030, 16'hFFFF, 16'd2, 4'd0);
        wait_done("t4_done", 200);
        idle_cycles(2);
        chk("t4_nacc", log_q.size(), 6);
        if (log_q.size() == 6) begin
            chk("t4_rd_wrap", {log_q[4].we, log_q[4].addr}, {1'b0, 16'h0000});
            chk("t4_wr_wrap", {log_q[5].we, log_q[5].addr, log_q[5].dat}, {1'b1, 16'h0000, 8'h44});
            chk("t4_wr_first", {log_q[2].addr, log_q[2].dat}, {16'hFFFF, 8'h33});
        end

        // abort coinciding with alpha_done
        log_q.delete(); done_cnt = 0; abort_hit = 0;
        run_job(16'h0050, 16'h0500, 16'd4, 4'd3);
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            if (alpha_en === 1'b1) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("t5_reach_blend", seen, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("t5_abort_hit", abort_hit, 1);
        chk("t5_after_abort", {busy, alpha_en, mem_wen, mem_ren, done}, 0);
        idle_cycles(5);
        chk("t5_no_write", count_writes(), 0);
        chk("t5_no_done", done_cnt, 0);

        // reset while a write is stalled
        log_q.delete();
        run_job(16'h0060, 16'h0600, 16'd1, 4'd2);
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            if (alpha_en === 1'b1) seen = 1;
            else begin @(posedge clk); #1; end
        end
        mem_stall = 1;
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (mem_wen === 1'b1) seen = 1;
        end
        chk("t6_reach_wr", seen, 1);
        idle_cycles(2);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_rst_req", {mem_wen, mem_ren, busy, alpha_en, done, read_done}, 0);
        chk("t6_rst_data", {mem_addr, mem_wdata, color1, color2, alpha_value}, 0);
        @(posedge clk); #1 n_rst = 1'b1; mem_stall = 0; act_cnt = 0;
        idle_cycles(10);
        chk("t6_no_reissue", act_cnt, 0);
        chk("t6_no_write", count_writes(), 0);

        // global protocol checks
        chk("rw_overlap", both_cnt, 0);
        chk("read_done_pulse", rd_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
